// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, architectural/physical register counts, the
// reset mapping for the alias table, the free-list initial contents and the
// per-slot renamed-operand bundle carried in the output register.
package rename_pkg;

  localparam int unsigned INST_ID_BITS = 6;
  localparam int unsigned PRN_BITS     = 6;
  localparam int unsigned ARN_BITS     = 5;
  localparam int unsigned MAX_OPERANDS = 3;
  localparam int unsigned FU_COUNT     = 4;
  localparam int unsigned FREE_PORTS   = 2;

  localparam int unsigned ARCH_REGS = 1 << ARN_BITS;
  localparam int unsigned PRN_COUNT = 1 << PRN_BITS;
  // Number of PRNs not bound to an architectural register after reset.
  localparam int unsigned FREE_INIT = PRN_COUNT - ARCH_REGS;
  // Free-list occupancy counter, wide enough to hold PRN_COUNT.
  localparam int unsigned CNT_BITS  = PRN_BITS + 1;
  // Per-instruction operand counter (0..MAX_OPERANDS).
  localparam int unsigned OPC_BITS  = $clog2(MAX_OPERANDS + 1);

  // One slot of a renamed instruction: source lookup plus destination alloc.
  typedef struct packed {
    logic                src_valid;
    logic                src_ready;
    logic [PRN_BITS-1:0] src_prn;
    logic                dst_valid;
    logic [PRN_BITS-1:0] dst_prn;
    logic [PRN_BITS-1:0] dst_prev;
  } rename_op_t;

  // Architectural register a maps to physical register a out of reset.
  function automatic logic [PRN_BITS-1:0] reset_map(input logic [ARN_BITS-1:0] a);
    return PRN_BITS'(a);
  endfunction

  // Free-list slot idx after reset: ARCH_REGS.. in ascending order, rest unused.
  function automatic logic [PRN_BITS-1:0] free_init_entry(input int unsigned idx);
    return (idx < FREE_INIT) ? PRN_BITS'(ARCH_REGS + idx) : '0;
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// free_list: circular buffer of free PRNs with PRN_COUNT entries.
//   pop_cnt        in   number of PRNs taken from the head this cycle
//   peek_prn[k]    out  entry at head+k (what the k-th pop would return)
//   push_valid/prn in   PRNs returned by commit, appended at tail in port order
//   count          out  current occupancy (registered; excludes this cycle's pushes)
// Head/tail are PRN_BITS wide so they wrap modulo PRN_COUNT for free.
module free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_BITS-1:0] pop_cnt,
  output logic [PRN_BITS-1:0] peek_prn   [MAX_OPERANDS],
  input  logic                push_valid [FREE_PORTS],
  input  logic [PRN_BITS-1:0] push_prn   [FREE_PORTS],
  output logic [CNT_BITS-1:0] count
);

  logic [PRN_BITS-1:0] mem_q [PRN_COUNT];
  logic [PRN_BITS-1:0] mem_d [PRN_COUNT];
  logic [PRN_BITS-1:0] head_q, head_d;
  logic [PRN_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] push_n_c;

  // Head-relative read window for the allocating slots.
  always_comb begin
    for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
      peek_prn[k] = mem_q[head_q + PRN_BITS'(k)];
    end
  end

  // Compacted tail writes, head advance and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    tail_d   = tail_q;
    push_n_c = '0;
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      if (push_valid[p]) begin
        mem_d[tail_d] = push_prn[p];
        tail_d        = tail_d + PRN_BITS'(1);
        push_n_c      = push_n_c + CNT_BITS'(1);
      end
    end
    head_d  = head_q + PRN_BITS'(pop_cnt);
    count_d = count_q - CNT_BITS'(pop_cnt) + push_n_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PRN_COUNT; i++) begin
        mem_q[i] <= free_init_entry(i);
      end
      head_q  <= '0;
      tail_q  <= PRN_BITS'(FREE_INIT);
      count_q <= CNT_BITS'(FREE_INIT);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Over-return (or pop underflow wrapping the counter) means a PRN leak upstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_d <= CNT_BITS'(FREE_INIT))
        else $error("free_list overflow: next count %0d", count_d);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps decoded architectural operands onto physical registers
// and hands one renamed instruction per cycle to the issue queue.
//   in_valid/in_ready        decode handshake (in_ready independent of in_valid)
//   in_inst_id/raw/pc        pass-through payload
//   src_*/dst_*              architectural operand slots
//   inst_valid/queue_ready   registered output handshake to the issue queue
//   prn_input*               renamed sources and their readiness
//   prn_output*/prn_prev     allocated destinations and their prior mappings
//   set_prn_ready/set_prn    FU wakeup broadcasts (clear busy bits)
//   free_valid/free_prn      PRNs returned by commit
// Optional: define RENAME_STATS_EN to add saturating stat_* counters.
module rename_stage
  import rename_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_ID_BITS-1:0] in_inst_id,
  input  logic [31:0]             in_raw_instr,
  input  logic [63:0]             in_pc,
  input  logic                    src_valid        [MAX_OPERANDS],
  input  logic [ARN_BITS-1:0]     src_arn          [MAX_OPERANDS],
  input  logic                    dst_valid        [MAX_OPERANDS],
  input  logic [ARN_BITS-1:0]     dst_arn          [MAX_OPERANDS],
  output logic                    inst_valid,
  input  logic                    queue_ready,
  output logic [INST_ID_BITS-1:0] inst_id,
  output logic [31:0]             raw_instr,
  output logic [63:0]             instr_pc,
  output logic                    prn_input_valid  [MAX_OPERANDS],
  output logic                    prn_input_ready  [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_input        [MAX_OPERANDS],
  output logic                    prn_output_valid [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_output       [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_prev         [MAX_OPERANDS],
  input  logic                    set_prn_ready    [FU_COUNT][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     set_prn          [FU_COUNT][MAX_OPERANDS],
  input  logic                    free_valid       [FREE_PORTS],
  input  logic [PRN_BITS-1:0]     free_prn         [FREE_PORTS]
`ifdef RENAME_STATS_EN
  ,
  output logic [31:0]             stat_renamed,
  output logic [31:0]             stat_stall_freelist,
  output logic [31:0]             stat_stall_iq
`endif
);

  logic [PRN_BITS-1:0]     rat_q [ARCH_REGS];
  logic [PRN_BITS-1:0]     rat_d [ARCH_REGS];
  logic [PRN_COUNT-1:0]    busy_q, busy_d;
  rename_op_t              ops_q [MAX_OPERANDS];
  rename_op_t              ops_d [MAX_OPERANDS];
  logic                    inst_valid_q, inst_valid_d;
  logic [INST_ID_BITS-1:0] inst_id_q, inst_id_d;
  logic [31:0]             raw_instr_q, raw_instr_d;
  logic [63:0]             instr_pc_q, instr_pc_d;

  logic [PRN_COUNT-1:0]    wake_vec_c;
  logic [OPC_BITS-1:0]     need_c;
  logic                    accept_c;
  logic                    hold_c;
  logic                    conflict_c;
  logic [OPC_BITS-1:0]     pop_cnt_c;
  logic [PRN_BITS-1:0]     alloc_prn_c [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     peek_prn    [MAX_OPERANDS];
  logic [CNT_BITS-1:0]     fl_count;

  // Flatten all FU wakeup broadcasts into one PRN-indexed vector.
  always_comb begin
    wake_vec_c = '0;
    for (int f = 0; f < int'(FU_COUNT); f++) begin
      for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
        if (set_prn_ready[f][k]) wake_vec_c[set_prn[f][k]] = 1'b1;
      end
    end
  end

  // Destination count and capacity gating; this cycle's frees are not counted.
  always_comb begin
    need_c = '0;
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      need_c = need_c + OPC_BITS'(dst_valid[i]);
    end
  end

  assign in_ready  = (!inst_valid_q || queue_ready) && (fl_count >= CNT_BITS'(need_c));
  assign accept_c  = in_valid && in_ready;
  assign hold_c    = inst_valid_q && !queue_ready;
  assign pop_cnt_c = accept_c ? need_c : '0;

  // Used destination slots take consecutive free-list entries, lowest slot first.
  always_comb begin
    logic [OPC_BITS-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      alloc_prn_c[i] = peek_prn[idx];
      if (dst_valid[i]) idx = idx + OPC_BITS'(1);
    end
  end

  free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_cnt    (pop_cnt_c),
    .peek_prn   (peek_prn),
    .push_valid (free_valid),
    .push_prn   (free_prn),
    .count      (fl_count)
  );

  // Output register, RAT and busy-table next state.
  always_comb begin
    ops_d        = ops_q;
    rat_d        = rat_q;
    inst_valid_d = inst_valid_q;
    inst_id_d    = inst_id_q;
    raw_instr_d  = raw_instr_q;
    instr_pc_d   = instr_pc_q;
    conflict_c   = 1'b0;
    // Wakeups clear first so a same-cycle allocation of that PRN wins.
    busy_d       = busy_q & ~wake_vec_c;

    if (hold_c) begin
      // Keep collecting wakeups for sources of the stalled instruction.
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        if (ops_q[i].src_valid && wake_vec_c[ops_q[i].src_prn]) ops_d[i].src_ready = 1'b1;
      end
    end else if (accept_c) begin
      inst_valid_d = 1'b1;
      inst_id_d    = in_inst_id;
      raw_instr_d  = in_raw_instr;
      instr_pc_d   = in_pc;
      // Sources read the RAT as it stood before this instruction's writes.
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        ops_d[i].src_valid = src_valid[i];
        ops_d[i].src_prn   = src_valid[i] ? rat_q[src_arn[i]] : '0;
        ops_d[i].src_ready = src_valid[i] &&
                             (!busy_q[rat_q[src_arn[i]]] || wake_vec_c[rat_q[src_arn[i]]]);
      end
      // Slots apply in ascending order: a repeated dst_arn ends on the higher
      // slot's PRN, and its prn_prev is the lower slot's PRN so that every
      // superseded mapping is returned exactly once at commit.
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        ops_d[i].dst_valid = dst_valid[i];
        ops_d[i].dst_prn   = '0;
        ops_d[i].dst_prev  = '0;
        if (dst_valid[i]) begin
          ops_d[i].dst_prn          = alloc_prn_c[i];
          ops_d[i].dst_prev         = rat_d[dst_arn[i]];
          rat_d[dst_arn[i]]         = alloc_prn_c[i];
          busy_d[alloc_prn_c[i]]    = 1'b1;
          if (wake_vec_c[alloc_prn_c[i]]) conflict_c = 1'b1;
        end
      end
    end else begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned a = 0; a < ARCH_REGS; a++) begin
        rat_q[a] <= reset_map(ARN_BITS'(a));
      end
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        ops_q[i] <= '0;
      end
      busy_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_id_q    <= '0;
      raw_instr_q  <= '0;
      instr_pc_q   <= '0;
    end else begin
      rat_q        <= rat_d;
      ops_q        <= ops_d;
      busy_q       <= busy_d;
      inst_valid_q <= inst_valid_d;
      inst_id_q    <= inst_id_d;
      raw_instr_q  <= raw_instr_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // A wakeup for a PRN that is still on the free list cannot happen legally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!conflict_c) else $error("rename_stage: wakeup hits a PRN being allocated");
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_id    = inst_id_q;
  assign raw_instr  = raw_instr_q;
  assign instr_pc   = instr_pc_q;

  always_comb begin
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      prn_input_valid[i]  = ops_q[i].src_valid;
      prn_input_ready[i]  = ops_q[i].src_ready;
      prn_input[i]        = ops_q[i].src_prn;
      prn_output_valid[i] = ops_q[i].dst_valid;
      prn_output[i]       = ops_q[i].dst_prn;
      prn_prev[i]         = ops_q[i].dst_prev;
    end
  end

`ifdef RENAME_STATS_EN
  logic [31:0] stat_renamed_q, stat_renamed_d;
  logic [31:0] stat_stall_fl_q, stat_stall_fl_d;
  logic [31:0] stat_stall_iq_q, stat_stall_iq_d;

  // Saturating event counters.
  always_comb begin
    stat_renamed_d  = stat_renamed_q;
    stat_stall_fl_d = stat_stall_fl_q;
    stat_stall_iq_d = stat_stall_iq_q;
    if (accept_c && (stat_renamed_q != 32'hFFFF_FFFF))
      stat_renamed_d = stat_renamed_q + 32'd1;
    if (in_valid && (fl_count < CNT_BITS'(need_c)) && (stat_stall_fl_q != 32'hFFFF_FFFF))
      stat_stall_fl_d = stat_stall_fl_q + 32'd1;
    if (in_valid && hold_c && (stat_stall_iq_q != 32'hFFFF_FFFF))
      stat_stall_iq_d = stat_stall_iq_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_renamed_q  <= '0;
      stat_stall_fl_q <= '0;
      stat_stall_iq_q <= '0;
    end else begin
      stat_renamed_q  <= stat_renamed_d;
      stat_stall_fl_q <= stat_stall_fl_d;
      stat_stall_iq_q <= stat_stall_iq_d;
    end
  end

  assign stat_renamed        = stat_renamed_q;
  assign stat_stall_freelist = stat_stall_fl_q;
  assign stat_stall_iq       = stat_stall_iq_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios followed by randomized traffic,
// every cycle compared against a queue/array reference model of renaming.
module tb_rename_stage;
  import rename_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [INST_ID_BITS-1:0] in_inst_id;
  logic [31:0]             in_raw_instr;
  logic [63:0]             in_pc;
  logic                    src_valid        [MAX_OPERANDS];
  logic [ARN_BITS-1:0]     src_arn          [MAX_OPERANDS];
  logic                    dst_valid        [MAX_OPERANDS];
  logic [ARN_BITS-1:0]     dst_arn          [MAX_OPERANDS];
  logic                    inst_valid;
  logic                    queue_ready;
  logic [INST_ID_BITS-1:0] inst_id;
  logic [31:0]             raw_instr;
  logic [63:0]             instr_pc;
  logic                    prn_input_valid  [MAX_OPERANDS];
  logic                    prn_input_ready  [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     prn_input        [MAX_OPERANDS];
  logic                    prn_output_valid [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     prn_output       [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     prn_prev         [MAX_OPERANDS];
  logic                    set_prn_ready    [FU_COUNT][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     set_prn          [FU_COUNT][MAX_OPERANDS];
  logic                    free_valid       [FREE_PORTS];
  logic [PRN_BITS-1:0]     free_prn         [FREE_PORTS];
`ifdef RENAME_STATS_EN
  logic [31:0] stat_renamed, stat_stall_freelist, stat_stall_iq;
`endif

  rename_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_pc(in_pc),
    .src_valid(src_valid), .src_arn(src_arn), .dst_valid(dst_valid), .dst_arn(dst_arn),
    .inst_valid(inst_valid), .queue_ready(queue_ready), .inst_id(inst_id),
    .raw_instr(raw_instr), .instr_pc(instr_pc),
    .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready), .prn_input(prn_input),
    .prn_output_valid(prn_output_valid), .prn_output(prn_output), .prn_prev(prn_prev),
    .set_prn_ready(set_prn_ready), .set_prn(set_prn),
    .free_valid(free_valid), .free_prn(free_prn)
`ifdef RENAME_STATS_EN
    , .stat_renamed(stat_renamed), .stat_stall_freelist(stat_stall_freelist),
    .stat_stall_iq(stat_stall_iq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: architectural map, busy set, FIFO of free PRNs, pool of
  // superseded PRNs awaiting commit, and the expected output register.
  int  m_rat  [ARCH_REGS];
  bit  m_busy [PRN_COUNT];
  int  m_free [$];
  int  m_pool [$];
  bit                    e_valid;
  logic [INST_ID_BITS-1:0] e_id;
  logic [31:0]           e_raw;
  logic [63:0]           e_pc;
  bit  e_siv [MAX_OPERANDS];
  bit  e_sr  [MAX_OPERANDS];
  int  e_sp  [MAX_OPERANDS];
  bit  e_dv  [MAX_OPERANDS];
  int  e_dp  [MAX_OPERANDS];
  int  e_pp  [MAX_OPERANDS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_mis++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int a = 0; a < int'(ARCH_REGS); a++) m_rat[a] = a;
    for (int p = 0; p < int'(PRN_COUNT); p++) m_busy[p] = 1'b0;
    m_free.delete();
    m_pool.delete();
    for (int p = int'(ARCH_REGS); p < int'(PRN_COUNT); p++) m_free.push_back(p);
    e_valid = 1'b0; e_id = '0; e_raw = '0; e_pc = '0;
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      e_siv[i] = 0; e_sr[i] = 0; e_sp[i] = 0; e_dv[i] = 0; e_dp[i] = 0; e_pp[i] = 0;
    end
  endtask

  function automatic int need_now();
    int n = 0;
    for (int i = 0; i < int'(MAX_OPERANDS); i++) if (dst_valid[i]) n++;
    return n;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step(input bit rdy);
    bit woke [PRN_COUNT];
    bit acc;
    for (int p = 0; p < int'(PRN_COUNT); p++) woke[p] = 0;
    for (int f = 0; f < int'(FU_COUNT); f++)
      for (int k = 0; k < int'(MAX_OPERANDS); k++)
        if (set_prn_ready[f][k]) woke[int'(set_prn[f][k])] = 1;
    acc = in_valid && rdy;
    if (e_valid && !queue_ready) begin
      for (int i = 0; i < int'(MAX_OPERANDS); i++)
        if (e_siv[i] && woke[e_sp[i]]) e_sr[i] = 1;
    end else if (acc) begin
      e_valid = 1; e_id = in_inst_id; e_raw = in_raw_instr; e_pc = in_pc;
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        e_siv[i] = src_valid[i];
        e_sp[i]  = src_valid[i] ? m_rat[int'(src_arn[i])] : 0;
        e_sr[i]  = src_valid[i] && (!m_busy[e_sp[i]] || woke[e_sp[i]]);
      end
    end else begin
      e_valid = 0;
    end
    for (int p = 0; p < int'(PRN_COUNT); p++) if (woke[p]) m_busy[p] = 0;
    if (acc && !(e_valid && !queue_ready && 0)) begin
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        e_dv[i] = dst_valid[i];
        e_dp[i] = 0;
        e_pp[i] = 0;
        if (dst_valid[i]) begin
          e_dp[i] = m_free.pop_front();
          e_pp[i] = m_rat[int'(dst_arn[i])];
          m_rat[int'(dst_arn[i])] = e_dp[i];
          m_busy[e_dp[i]] = 1;
          m_pool.push_back(e_pp[i]);
        end
      end
    end
    for (int p = 0; p < int'(FREE_PORTS); p++)
      if (free_valid[p]) m_free.push_back(int'(free_prn[p]));
  endtask

  task automatic compare_outputs();
    chk("inst_valid", inst_valid, e_valid);
    if (e_valid) begin
      chk("inst_id", inst_id, e_id);
      chk("raw_instr", raw_instr, e_raw);
      chk("instr_pc", instr_pc, e_pc);
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        chk($sformatf("prn_input_valid[%0d]", i), prn_input_valid[i], e_siv[i]);
        chk($sformatf("prn_input[%0d]", i), prn_input[i], e_sp[i]);
        chk($sformatf("prn_input_ready[%0d]", i), prn_input_ready[i], e_sr[i]);
        chk($sformatf("prn_output_valid[%0d]", i), prn_output_valid[i], e_dv[i]);
        chk($sformatf("prn_output[%0d]", i), prn_output[i], e_dp[i]);
        chk($sformatf("prn_prev[%0d]", i), prn_prev[i], e_pp[i]);
      end
    end
  endtask

  // Called at a falling edge with inputs set; ends at the next falling edge.
  task automatic cycle();
    bit exp_rdy;
    #1;
    exp_rdy = (!e_valid || queue_ready) && (m_free.size() >= need_now());
    chk("in_ready", in_ready, exp_rdy);
    model_step(exp_rdy);
    @(posedge clk);
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_inst_id = '0; in_raw_instr = '0; in_pc = '0; queue_ready = 1;
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      src_valid[i] = 0; src_arn[i] = '0; dst_valid[i] = 0; dst_arn[i] = '0;
    end
    for (int f = 0; f < int'(FU_COUNT); f++)
      for (int k = 0; k < int'(MAX_OPERANDS); k++) begin
        set_prn_ready[f][k] = 0; set_prn[f][k] = '0;
      end
    for (int p = 0; p < int'(FREE_PORTS); p++) begin
      free_valid[p] = 0; free_prn[p] = '0;
    end
  endtask

  task automatic new_ins(input int id);
    clear_inputs();
    in_valid = 1; in_inst_id = INST_ID_BITS'(id);
    in_raw_instr = $urandom; in_pc = {$urandom, $urandom};
  endtask

  task automatic src(input int i, input int a);
    src_valid[i] = 1; src_arn[i] = ARN_BITS'(a);
  endtask

  task automatic dst(input int i, input int a);
    dst_valid[i] = 1; dst_arn[i] = ARN_BITS'(a);
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs(); model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int f0, f1;
    int cand [$];
    bit in_fl [PRN_COUNT];
    rst = 1; clear_inputs(); model_reset();
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state.
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_inst_id", inst_id, 0);
    chk("rst_pc", instr_pc, 0);
    for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
      chk("rst_prn_input", prn_input[i], 0);
      chk("rst_prn_output", prn_output[i], 0);
      chk("rst_prn_prev", prn_prev[i], 0);
    end
    @(negedge clk);

    // src x1,x2 dst x3, then the next allocation.
    new_ins(1); src(0, 1); src(1, 2); dst(0, 3); cycle();
    chk("t1_src0", prn_input[0], 1);
    chk("t1_src1", prn_input[1], 2);
    chk("t1_rdy0", prn_input_ready[0], 1);
    chk("t1_rdy1", prn_input_ready[1], 1);
    chk("t1_dst", prn_output[0], 32);
    chk("t1_prev", prn_prev[0], 3);
    new_ins(2); dst(0, 6); cycle();
    chk("t1_next_dst", prn_output[0], 33);

    // Wakeup while the consumer is held at the output.
    do_reset();
    new_ins(3); dst(0, 5); cycle();
    chk("t2_a_dst", prn_output[0], 32);
    new_ins(4); src(0, 5); cycle();
    chk("t2_b_src", prn_input[0], 32);
    chk("t2_b_busy", prn_input_ready[0], 0);
    clear_inputs(); queue_ready = 0; cycle();
    chk("t2_held_busy", prn_input_ready[0], 0);
    clear_inputs(); queue_ready = 0; set_prn_ready[1][2] = 1; set_prn[1][2] = 6'd32; cycle();
    chk("t2_held_valid", inst_valid, 1);
    chk("t2_held_woken", prn_input_ready[0], 1);
    clear_inputs(); cycle();

    // Wakeup in the same cycle the consumer is renamed.
    do_reset();
    new_ins(5); dst(0, 5); cycle();
    new_ins(6); src(0, 5); set_prn_ready[3][0] = 1; set_prn[3][0] = 6'd32; cycle();
    chk("t3_same_cycle_wake", prn_input_ready[0], 1);

    // Exhaust the free list, then return two PRNs.
    do_reset();
    for (int n = 0; n < 11; n++) begin
      new_ins(8 + n); dst(0, (3 * n) % 32); dst(1, (3 * n + 1) % 32);
      if (n < 10) dst(2, (3 * n + 2) % 32);
      cycle();
    end
    new_ins(20); dst(0, 1); #1;
    chk("t4_fl_stall", in_ready, 0);
    cycle();
    new_ins(21); src(0, 3); #1;
    chk("t4_nodst_ready", in_ready, 1);
    cycle();
    chk("t4_nodst_pass", inst_valid, 1);
    new_ins(22); dst(0, 2); dst(1, 3);
    f0 = m_pool.pop_front(); f1 = m_pool.pop_front();
    free_valid[0] = 1; free_prn[0] = PRN_BITS'(f0);
    free_valid[1] = 1; free_prn[1] = PRN_BITS'(f1);
    #1;
    chk("t4_free_not_same_cycle", in_ready, 0);
    cycle();
    free_valid[0] = 0; free_valid[1] = 0; #1;
    chk("t4_free_next_cycle", in_ready, 1);
    cycle();
    chk("t4_realloc0", prn_output[0], f0);
    chk("t4_realloc1", prn_output[1], f1);

    // src==dst within one instruction; duplicate destinations.
    do_reset();
    new_ins(30); src(0, 4); dst(0, 4); cycle();
    chk("t5_src_old", prn_input[0], 4);
    chk("t5_dst_new", prn_output[0], 32);
    new_ins(31); dst(0, 7); dst(1, 7); cycle();
    chk("t5_dup0", prn_output[0], 33);
    chk("t5_dup1", prn_output[1], 34);
    new_ins(32); src(0, 4); src(1, 7); cycle();
    chk("t5_rat4", prn_input[0], 32);
    chk("t5_rat7", prn_input[1], 34);

    // Asynchronous reset mid-stall with 10 PRNs left.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      new_ins(40 + n); dst(0, n); if (n < 7) begin dst(1, n + 8); dst(2, n + 16); end
      cycle();
    end
    clear_inputs(); queue_ready = 0; cycle();
    chk("t6_stalled", inst_valid, 1);
    #2 rst = 1;
    #1;
    chk("t6_async_clear", inst_valid, 0);
    clear_inputs(); model_reset();
    @(negedge clk);
    rst = 0;
    new_ins(50); src(0, 5); src(1, 9); src(2, 31); dst(0, 1); dst(1, 2); dst(2, 3); cycle();
    chk("t6_rat5", prn_input[0], 5);
    chk("t6_rat31", prn_input[2], 31);
    chk("t6_alloc0", prn_output[0], 32);
    chk("t6_alloc2", prn_output[2], 34);
    for (int n = 0; n < 9; n++) begin
      new_ins(51 + n); dst(0, n); dst(1, n + 10); dst(2, n + 20); cycle();
    end
    new_ins(60); dst(0, 1); dst(1, 2); dst(2, 3); #1;
    chk("t6_two_left_stall3", in_ready, 0);
    new_ins(61); dst(0, 1); dst(1, 2); #1;
    chk("t6_two_left_pass2", in_ready, 1);
    cycle();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      in_valid = ($urandom_range(0, 3) != 0);
      in_inst_id = INST_ID_BITS'($urandom); in_raw_instr = $urandom; in_pc = {$urandom, $urandom};
      queue_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
        src_valid[i] = $urandom_range(0, 1); src_arn[i] = ARN_BITS'($urandom);
        dst_valid[i] = ($urandom_range(0, 2) == 0); dst_arn[i] = ARN_BITS'($urandom);
      end
      for (int p = 0; p < int'(PRN_COUNT); p++) in_fl[p] = 0;
      foreach (m_free[q]) in_fl[m_free[q]] = 1;
      cand.delete();
      for (int p = 0; p < int'(PRN_COUNT); p++) if (m_busy[p] && !in_fl[p]) cand.push_back(p);
      for (int f = 0; f < int'(FU_COUNT); f++)
        for (int k = 0; k < int'(MAX_OPERANDS); k++)
          if (cand.size() > 0 && $urandom_range(0, 5) == 0) begin
            set_prn_ready[f][k] = 1;
            set_prn[f][k] = PRN_BITS'(cand[$urandom_range(0, cand.size() - 1)]);
          end
      for (int p = 0; p < int'(FREE_PORTS); p++)
        if (m_pool.size() > 0 && $urandom_range(0, 2) == 0) begin
          free_valid[p] = 1; free_prn[p] = PRN_BITS'(m_pool.pop_front());
        end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage directly upstream of the issue queue.
- Takes decoded architectural operands and maps sources through a register alias table (RAT).
- Allocates physical registers for destinations from a free list and tracks per-PRN busy bits.
- Presents one renamed instruction per cycle to the issue queue through a registered valid/ready handshake; commit returns freed PRNs.

Parameters:
INST_ID_BITS, 6, instruction tag width
PRN_BITS, 6, physical register number width; PRN_COUNT = 2**PRN_BITS
ARN_BITS, 5, architectural register number width; ARCH_REGS = 2**ARN_BITS
MAX_OPERANDS, 3, source and destination slots per instruction
FU_COUNT, 4, wakeup broadcast sources
FREE_PORTS, 2, PRNs returned per cycle by commit

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts this cycle
in_inst_id  in  INST_ID_BITS  tag
in_raw_instr  in  32  raw encoding
in_pc  in  64  PC
src_valid[MAX_OPERANDS]  in  1  source slot used
src_arn[MAX_OPERANDS]  in  ARN_BITS  source architectural reg
dst_valid[MAX_OPERANDS]  in  1  destination slot used
dst_arn[MAX_OPERANDS]  in  ARN_BITS  destination architectural reg
inst_valid  out  1  to issue queue
queue_ready  in  1  issue queue has a slot
inst_id, raw_instr, instr_pc  out  INST_ID_BITS/32/64  pass-through
prn_input_valid/prn_input_ready/prn_input[MAX_OPERANDS]  out  1/1/PRN_BITS  renamed sources
prn_output_valid/prn_output[MAX_OPERANDS]  out  1/PRN_BITS  allocated destinations
prn_prev[MAX_OPERANDS]  out  PRN_BITS  prior mapping of each destination, to the ROB for later free
set_prn_ready[FU_COUNT][MAX_OPERANDS]  in  1  wakeup strobe
set_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS  woken PRN
free_valid[FREE_PORTS], free_prn[FREE_PORTS]  in  1/PRN_BITS  commit returns PRNs

Behaviour:
- Reset (asynchronous, any cycle, including mid-stall):
  - RAT[a] = a; all busy bits = 0.
  - Free list holds ARCH_REGS..PRN_COUNT-1 in ascending order, head = 0, count = PRN_COUNT - ARCH_REGS.
  - inst_valid = 0; all other outputs = 0.
- Latency: one cycle. An instruction accepted in cycle N appears on the outputs in cycle N+1.
- Capacity gating:
  - need = popcount(dst_valid).
  - in_ready = (!inst_valid || queue_ready) && (count >= need).
  - in_ready must not depend on in_valid.
- Hold: the output holds while inst_valid && !queue_ready.
- Source lookup:
  - prn_input[i] = RAT[src_arn[i]] read before this instruction's own destination writes, so a same-instruction src==dst uses the old mapping.
  - prn_input_ready[i] = !busy[prn] || any same-cycle wakeup matching prn.
- Destinations:
  - Pop PRNs from the free list in slot order, lowest slot first.
  - Write RAT; capture the old RAT value into prn_prev; set busy.
  - Duplicate dst_arn within one instruction: the higher slot's mapping wins in RAT. Each slot still gets its own PRN.
- Held output: each cycle, a wakeup matching a held prn_input[i] sets prn_input_ready[i] = 1, so no wakeup is lost between rename and issue-queue insert.
- Busy vs wakeup: allocation sets busy and wakeup clears it. If both target the same PRN in one cycle, allocation wins; this is illegal by construction and flagged by assertion.
- Free list:
  - Circular buffer with PRN_COUNT entries, head/tail wrap modulo PRN_COUNT.
  - Next count = count - pops + pushes (simultaneous push/pop allowed).
  - A push taking count above PRN_COUNT - ARCH_REGS is an assertion error.
  - Frees from the same cycle are not visible to that cycle's in_ready.

Optional Feature:
RENAME_STATS_EN:
- Defined: adds outputs stat_renamed[31:0], stat_stall_freelist[31:0] and stat_stall_iq[31:0].
  - These are saturating counters of accepted instructions, cycles with in_valid && count<need, and cycles with in_valid && inst_valid && !queue_ready.
  - They reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package rename_pkg: ARCH_REGS/PRN_COUNT localparams, reset-mapping function, typedef for renamed-operand bundle.
- One sub-module: free_list (multi-pop/multi-push circular buffer with count output). RAT, busy table and output register stay in rename_stage.

Test Plan:
- Reset, then instr src x1,x2 dst x3 -> prn_input=1,2 ready=1,1; prn_output=32; prn_prev=3; next dst allocation gets 33.
- Instr A dst x5 (gets 32); B src x5 -> B prn_input=32 ready=0; set_prn=32 strobe while B held with queue_ready=0 -> ready flips to 1 before insert.
- Wakeup for PRN 32 in the same cycle B is renamed -> B emitted with prn_input_ready=1.
- Allocate 32 PRNs with no frees -> count=0, in_ready=0 for any dst instruction; an instruction with no destinations still passes. Then free 2 PRNs -> stall clears next cycle.
- Same instruction src x4 dst x4 -> prn_input=4 (old), prn_output new, RAT[4] updated; dst slots 0 and 1 both x7 -> RAT[7] = slot 1's PRN.
- Assert rst while inst_valid=1 and count=10 -> inst_valid=0 immediately, count=32, RAT identity.
